// File: rtl/amdc_eddy_current_sample_avg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : amdc_eddy_current_sample_avg
// Brief    : Captures X/Y eddy current samples on the SPI master's done rise
//            and publishes a 2^n boxcar average with a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module amdc_eddy_current_sample_avg #(
  parameter int DATA_W   = 18,
  parameter int MAX_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [2:0]        avg_log2,
  input  logic              done,
  input  logic [DATA_W-1:0] sensor_data_x,
  input  logic [DATA_W-1:0] sensor_data_y,
  output logic [DATA_W-1:0] avg_x,
  output logic [DATA_W-1:0] avg_y,
  output logic              avg_valid,
  output logic [15:0]       sample_cnt,
  output logic              busy
);

  localparam int ACC_W = DATA_W + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam int N_W   = $clog2(MAX_LOG2 + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic                     r_done_d;
  logic                     w_done_rise;
  logic                     r_cap_v;
  logic [DATA_W-1:0]        r_cap_x;
  logic [DATA_W-1:0]        r_cap_y;
  logic signed [ACC_W-1:0]  r_acc_x;
  logic signed [ACC_W-1:0]  r_acc_y;
  logic signed [ACC_W-1:0]  w_ext_x;
  logic signed [ACC_W-1:0]  w_ext_y;
  logic [CNT_W-1:0]         r_win_cnt;
  logic [CNT_W-1:0]         w_win_target;
  logic [N_W-1:0]           r_n;
  logic [N_W-1:0]           w_n_req;
  logic [DATA_W-1:0]        r_avg_x;
  logic [DATA_W-1:0]        r_avg_y;
  logic                     r_avg_valid;
  logic [15:0]              r_sample_cnt;
  logic                     w_flush;

  assign w_done_rise  = done & ~r_done_d;
  assign w_flush      = clear | ~enable;
  assign w_ext_x      = {{MAX_LOG2{r_cap_x[DATA_W-1]}}, r_cap_x};
  assign w_ext_y      = {{MAX_LOG2{r_cap_y[DATA_W-1]}}, r_cap_y};
  assign w_win_target = CNT_W'(1) << r_n;
  assign w_n_req      = (32'(avg_log2) > MAX_LOG2) ? N_W'(MAX_LOG2) : N_W'(avg_log2);

  // Edge detect and capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_d <= 1'b0;
      r_cap_v  <= 1'b0;
      r_cap_x  <= '0;
      r_cap_y  <= '0;
    end else begin
      r_done_d <= done;
      r_cap_v  <= w_done_rise & enable & ~clear;
      if (w_done_rise && enable && !clear) begin
        r_cap_x <= sensor_data_x;
        r_cap_y <= sensor_data_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A sample captured during OUTPUT leaves win_cnt nonzero in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_cap_v || (r_win_cnt != '0)) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        if (r_win_cnt == w_win_target) w_state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (w_flush) w_state_next = S_IDLE;
  end

  // Accumulate and output stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_x      <= '0;
      r_acc_y      <= '0;
      r_win_cnt    <= '0;
      r_n          <= '0;
      r_avg_x      <= '0;
      r_avg_y      <= '0;
      r_avg_valid  <= 1'b0;
      r_sample_cnt <= '0;
    end else if (clear) begin
      r_acc_x      <= '0;
      r_acc_y      <= '0;
      r_win_cnt    <= '0;
      r_avg_x      <= '0;
      r_avg_y      <= '0;
      r_avg_valid  <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_avg_valid <= 1'b0;
      if (!enable) begin
        r_acc_x   <= '0;
        r_acc_y   <= '0;
        r_win_cnt <= '0;
      end else if (r_state == S_OUTPUT) begin
        r_avg_x     <= DATA_W'(r_acc_x >>> r_n);
        r_avg_y     <= DATA_W'(r_acc_y >>> r_n);
        r_avg_valid <= 1'b1;
        if (r_cap_v) begin
          // Back-to-back sample opens the next window immediately
          r_acc_x      <= w_ext_x;
          r_acc_y      <= w_ext_y;
          r_win_cnt    <= CNT_W'(1);
          r_n          <= w_n_req;
          r_sample_cnt <= r_sample_cnt + 16'd1;
        end else begin
          r_acc_x   <= '0;
          r_acc_y   <= '0;
          r_win_cnt <= '0;
        end
      end else if (r_cap_v) begin
        r_acc_x      <= r_acc_x + w_ext_x;
        r_acc_y      <= r_acc_y + w_ext_y;
        r_win_cnt    <= r_win_cnt + CNT_W'(1);
        r_sample_cnt <= r_sample_cnt + 16'd1;
        if (r_win_cnt == '0) r_n <= w_n_req;
      end
    end
  end

  assign avg_x      = r_avg_x;
  assign avg_y      = r_avg_y;
  assign avg_valid  = r_avg_valid;
  assign sample_cnt = r_sample_cnt;
  assign busy       = ((r_state == S_ACCUM) || (r_state == S_OUTPUT)) && (r_win_cnt != '0);

endmodule
`default_nettype wire

// File: doc/amdc_eddy_current_sample_avg.md
Name: amdc_eddy_current_sample_avg

Overview:
Downstream stage of the eddy current sensor SPI master. It captures each completed 18-bit X/Y conversion on the rising edge of the master's done flag. It sign-extends the samples, accumulates 2^N of them per channel, and publishes a boxcar average with a one-cycle valid strobe. Its outputs feed the eddy current IP's AXI register file and the control-loop interface.

Parameters:
DATA_W, 18, sample width from the SPI master (AD4011 two's complement)
MAX_LOG2, 4, largest supported log2 of the averaging window (max window of 16 samples)

Ports:
clk  input  1  AXI clock (200 MHz); the only clock
rst_n  input  1  asynchronous, active-low reset
enable  input  1  averaging enable from the register file
clear  input  1  synchronous clear of window, outputs and counter
avg_log2  input  3  requested window is 2^avg_log2 samples; clamped to MAX_LOG2
done  input  1  SPI master done level: rises when data is valid, falls at the next start
sensor_data_x  input  DATA_W  X sample from the SPI master, stable while done=1
sensor_data_y  input  DATA_W  Y sample from the SPI master, stable while done=1
avg_x  output  DATA_W  signed X average
avg_y  output  DATA_W  signed Y average
avg_valid  output  1  one-cycle strobe: new averages loaded
sample_cnt  output  16  raw samples accepted, wraps
busy  output  1  high while a window is partially filled

Behaviour:
- Reset (rst_n low, async):
  - avg_x, avg_y, avg_valid, sample_cnt, busy = 0
  - accumulators, window counter and done_d = 0
  - FSM = IDLE
- Edge detect:
  - done_d is a registered copy of done.
  - done_rise = done & ~done_d.
  - A level-high done that persists never generates more than one sample.
- Stage 1 (capture): at the clk edge where done_rise=1 and enable=1, register both samples and set cap_v for one cycle.
- Stage 2 (accumulate), on cap_v:
  - acc_x += sign-extended sample, acc_y likewise. Accumulator width is DATA_W+MAX_LOG2, signed.
  - win_cnt += 1; sample_cnt += 1, wrapping 0xFFFF to 0.
- Stage 3 (output):
  - Condition: win_cnt == 2^n, where n is the latched window size.
  - avg_x = acc_x >>> n, arithmetic shift, floor toward -inf. avg_y likewise.
  - avg_valid = 1 for exactly one cycle.
  - acc, win_cnt cleared.
- Latency: with done first sampled high at edge E0, the final sample of a window produces avg_valid high after edge E0+3 and low after E0+4.
- Window size:
  - n = min(avg_log2, MAX_LOG2), latched when a sample enters an empty window (win_cnt=0).
  - Changing avg_log2 mid-window has no effect until the next window.
  - n=0 gives a pass-through: every sample produces avg_valid and avg = sample.
- FSM states: IDLE, ACCUM, OUTPUT.
  - IDLE -> ACCUM: first cap_v.
  - ACCUM -> OUTPUT: win_cnt reaches 2^n.
  - ACCUM stays in ACCUM otherwise.
  - OUTPUT -> IDLE: unconditional after one cycle.
  - Unused or illegal state -> IDLE.
- busy = 1 in ACCUM and OUTPUT when win_cnt != 0; otherwise 0.
- Boundary conditions:
  - Full-scale inputs (all 0x1FFFF or all 0x20000) must not overflow the accumulator for any n ≤ MAX_LOG2.
  - enable low: no new captures. A partial window is discarded; acc and win_cnt are cleared on the next cycle. avg_x/avg_y hold their last values. sample_cnt holds.
  - clear: same effect as enable low, plus avg_x, avg_y and sample_cnt are set to 0. clear has priority over a simultaneous done_rise or cap_v, and that sample is dropped.
  - done_rise while OUTPUT is active is captured normally. The pipeline accepts one sample per cycle. The SPI master's minimum spacing is at least 40 cycles.
  - rst_n asserted mid-window: all state returns to reset values immediately. No avg_valid is produced for the partial window.

Test Plan:
- Reset, then avg_log2=0, enable=1; one done pulse with x=0x00123, y=0x3FFFF -> avg_valid after E0+3; avg_x=0x00123, avg_y=0x3FFFF; sample_cnt=1.
- avg_log2=2; four samples x = 10, 20, 30, 41 -> one avg_valid only after the 4th; avg_x=25 (101>>2). busy=1 between samples 1 and 4.
- avg_log2=4; sixteen samples x=0x1FFFF then sixteen x=0x20000 -> avg_x=0x1FFFF then 0x20000; no overflow.
- avg_log2=1; samples x=-1 (0x3FFFF) and x=0 -> avg_x=0x3FFFF (floor of -0.5 is -1).
- done held high 100 cycles -> exactly one sample captured. clear asserted on the same cycle as done_rise -> sample dropped, sample_cnt=0, avg_x=0.
- avg_log2=7 -> clamped to window 16. Deassert enable after 3 samples -> busy=0 next cycle; the next window needs a full 16 new samples.
